// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART command sequencer.
// UART_CMD_ACK_EN adds the write-acknowledge states.
package uart_pkg;

  localparam logic [7:0] HDR_BYTE = 8'h12;
  localparam logic [7:0] OP_WR    = 8'h56;
  localparam logic [7:0] OP_RD    = 8'h34;
  localparam logic [7:0] ACK_BYTE = 8'hAC;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPC,
    ST_ADDR,
    ST_LEN,
    ST_WDATA,
    ST_RREQ,
    ST_RCAP,
    ST_TXWAIT
`ifdef UART_CMD_ACK_EN
    ,
    ST_ACK,
    ST_ACKWAIT
`endif
  } state_t;

  // Only the frame-receive states are bounded by the inter-byte timeout.
  function automatic logic counts_timeout(input state_t s);
    return (s == ST_OPC) || (s == ST_ADDR) || (s == ST_LEN) || (s == ST_WDATA);
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Framed UART command parser driving an 8-bit register bus; write strobes 1 cycle after rx_done, tx_wr 1 cycle after reg_re.
// One tx byte in flight, paced by tx_done; rx bytes during a read reply are dropped. UART_CMD_ACK_EN enables write ACK (8'hAC).
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // err is registered, so trip one count early to land the pulse
  // exactly TIMEOUT_CYCLES cycles after the last rx_done.
  localparam logic [TW-1:0] TMO_TRIP = TW'(TIMEOUT_CYCLES - 2);

`ifdef UART_CMD_ACK_EN
  localparam state_t WR_END = ST_ACK;
`else
  localparam state_t WR_END = ST_IDLE;
`endif

  state_t        state, state_nxt;
  logic          is_rd, is_rd_nxt;
  logic [7:0]    addr_q, addr_nxt;
  logic [7:0]    len_q, len_nxt;
  logic [7:0]    tx_q, tx_nxt;
  logic [TW-1:0] tmo_q, tmo_nxt;
  logic          reg_we_q, reg_we_nxt;
  logic [7:0]    reg_addr_q, reg_addr_nxt;
  logic [7:0]    reg_wdata_q, reg_wdata_nxt;
  logic          err_q, err_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      is_rd       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      tx_q        <= '0;
      tmo_q       <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      is_rd       <= is_rd_nxt;
      addr_q      <= addr_nxt;
      len_q       <= len_nxt;
      tx_q        <= tx_nxt;
      tmo_q       <= tmo_nxt;
      reg_we_q    <= reg_we_nxt;
      reg_addr_q  <= reg_addr_nxt;
      reg_wdata_q <= reg_wdata_nxt;
      err_q       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    is_rd_nxt     = is_rd;
    addr_nxt      = addr_q;
    len_nxt       = len_q;
    tmo_nxt       = '0;
    reg_we_nxt    = 1'b0;
    reg_addr_nxt  = reg_addr_q;
    reg_wdata_nxt = reg_wdata_q;
    err_nxt       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_done && rx_data == HDR_BYTE) state_nxt = ST_OPC;
      end
      ST_OPC: begin
        if (rx_done) begin
          if (rx_data == OP_WR) begin
            is_rd_nxt = 1'b0;
            state_nxt = ST_ADDR;
          end else if (rx_data == OP_RD) begin
            is_rd_nxt = 1'b1;
            state_nxt = ST_ADDR;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_ADDR: begin
        if (rx_done) begin
          addr_nxt  = rx_data;
          state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_done) begin
          len_nxt = rx_data;
          if (rx_data == 8'd0) begin
            state_nxt = is_rd ? ST_IDLE : WR_END;
          end else if (is_rd) begin
            state_nxt    = ST_RREQ;
            reg_addr_nxt = addr_q;
          end else begin
            state_nxt = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (rx_done) begin
          reg_we_nxt    = 1'b1;
          reg_addr_nxt  = addr_q;
          reg_wdata_nxt = rx_data;
          addr_nxt      = addr_q + 8'd1;
          len_nxt       = len_q - 8'd1;
          if (len_q == 8'd1) state_nxt = WR_END;
        end
      end
      ST_RREQ:  state_nxt = ST_RCAP;
      ST_RCAP:  state_nxt = ST_TXWAIT;
      ST_TXWAIT: begin
        if (tx_done) begin
          addr_nxt = addr_q + 8'd1;
          len_nxt  = len_q - 8'd1;
          if (len_q == 8'd1) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt    = ST_RREQ;
            reg_addr_nxt = addr_q + 8'd1;
          end
        end
      end
`ifdef UART_CMD_ACK_EN
      ST_ACK:     state_nxt = ST_ACKWAIT;
      ST_ACKWAIT: if (tx_done) state_nxt = ST_IDLE;
`endif
      default:  state_nxt = ST_IDLE;
    endcase

    // A byte arriving in the expiry cycle keeps the frame alive.
    if (counts_timeout(state) && !rx_done && tmo_q == TMO_TRIP) begin
      err_nxt   = 1'b1;
      state_nxt = ST_IDLE;
    end else if (counts_timeout(state_nxt) && !rx_done) begin
      tmo_nxt = tmo_q + TW'(1);
    end
  end

  always_comb begin
    tx_wr   = (state == ST_RCAP);
    tx_data = tx_q;
    if (state == ST_RCAP) tx_data = reg_rdata;
`ifdef UART_CMD_ACK_EN
    if (state == ST_ACK) begin
      tx_wr   = 1'b1;
      tx_data = ACK_BYTE;
    end
`endif
  end

  assign tx_nxt    = tx_wr ? tx_data : tx_q;
  assign reg_re    = (state == ST_RREQ);
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign err       = err_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected writes, tx bytes and err cycles; a negedge monitor pops and compares.
module tb_uart_cmd_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = '0;
  logic       busy;
  logic       err;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(50)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {int cyc; logic [7:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [7:0] b; bit rd; bit more;} tx_t;
  wr_t exp_wr[$];
  tx_t exp_tx[$];
  int  exp_err[$];

  wr_t we_e;
  tx_t tx_e;
  int  er_e;
  int  last_re_cyc = -10;
  int  want_re_cyc = -10;
  bit  tx_out = 1'b0;
  bit  cur_more = 1'b0;

  // Register file: synchronous read, data valid the cycle after reg_re.
  initial begin
    logic [7:0] nv;
    forever begin
      @(negedge sys_clk);
      nv = reg_re ? (reg_addr ^ 8'h5A) : 8'h00;
      @(posedge sys_clk);
      #1 reg_rdata = nv;
    end
  end

  // Transceiver: finishes each byte 4 cycles after its tx_wr.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_wr) begin
        repeat (4) @(posedge sys_clk);
        #1 tx_done = 1'b1;
        @(posedge sys_clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      tx_out = 1'b0;
      cur_more = 1'b0;
      want_re_cyc = -10;
    end else begin
      if (reg_we || reg_re) begin
        checks++;
        if (reg_we && reg_re) begin
          errors++;
          $display("FAIL we_re_overlap we=%0b re=%0b need not both", reg_we, reg_re);
        end
      end
      if (cyc == want_re_cyc) begin
        checks++;
        if (!reg_re) begin
          errors++;
          $display("FAIL re_after_txdone reg_re=%0b at cyc %0d need 1", reg_re, cyc);
        end
      end
      if (reg_re) last_re_cyc = cyc;
      if (reg_we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected addr=%h data=%h need no write", reg_addr, reg_wdata);
        end else begin
          we_e = exp_wr.pop_front();
          if (reg_addr !== we_e.a || reg_wdata !== we_e.d || cyc != we_e.cyc) begin
            errors++;
            $display("FAIL wr addr=%h data=%h cyc=%0d need addr=%h data=%h cyc=%0d",
                     reg_addr, reg_wdata, cyc, we_e.a, we_e.d, we_e.cyc);
          end
        end
      end
      if (tx_wr) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected byte=%h need no tx", tx_data);
        end else begin
          tx_e = exp_tx.pop_front();
          if (tx_data !== tx_e.b || tx_out || (tx_e.rd && last_re_cyc != cyc - 1)) begin
            errors++;
            $display("FAIL tx byte=%h inflight=%0b re_gap=%0d need byte=%h inflight=0 re_gap=%0d",
                     tx_data, tx_out, cyc - last_re_cyc, tx_e.b, tx_e.rd ? 1 : cyc - last_re_cyc);
          end
          cur_more = tx_e.more;
        end
        tx_out = 1'b1;
      end
      if (tx_done) begin
        tx_out = 1'b0;
        if (cur_more) want_re_cyc = cyc + 1;
        cur_more = 1'b0;
      end
      if (err) begin
        checks++;
        if (exp_err.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected at cyc %0d need no err", cyc);
        end else begin
          er_e = exp_err.pop_front();
          if (cyc != er_e) begin
            errors++;
            $display("FAIL err_cycle cyc=%0d need %0d", cyc, er_e);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output int c);
    @(posedge sys_clk);
    #1 rx_data = b;
    rx_done = 1'b1;
    c = cyc;
    @(posedge sys_clk);
    #1 rx_done = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    int c;
    send(b0, c); send(b1, c); send(b2, c); send(b3, c);
  endtask

  task automatic send_wr_data(input logic [7:0] a, input logic [7:0] d);
    int c;
    send(d, c);
    exp_wr.push_back('{cyc: c + 1, a: a, d: d});
  endtask

  task automatic push_ack();
`ifdef UART_CMD_ACK_EN
    exp_tx.push_back('{b: 8'hAC, rd: 1'b0, more: 1'b0});
`endif
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (busy && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s busy=%0b need 0 within 300 cycles", name, busy);
    end
  endtask

  task automatic check_zero(input string name);
    logic [28:0] v;
    v = {tx_data, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy, err};
    checks++;
    if (v !== 29'd0) begin
      errors++;
      $display("FAIL %s outputs=%h need 0", name, v);
    end
  endtask

  initial begin
    int c;
    int n;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_zero("reset_outputs");
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // Garbage before header, then 3-byte write.
    send(8'h00, c); send(8'hFF, c);
    send_seq(8'h12, 8'h56, 8'h01, 8'h03);
    send_wr_data(8'h01, 8'hAA);
    send_wr_data(8'h02, 8'hBB);
    send_wr_data(8'h03, 8'hCC);
    push_ack();
    wait_idle("write3_idle");

    // Read with address wrap FE, FF, 00.
    exp_tx.push_back('{b: 8'hA4, rd: 1'b1, more: 1'b1});
    exp_tx.push_back('{b: 8'hA5, rd: 1'b1, more: 1'b1});
    exp_tx.push_back('{b: 8'h5A, rd: 1'b1, more: 1'b0});
    send_seq(8'h12, 8'h34, 8'hFE, 8'h03);
    wait_idle("read3_idle");

    // Bad opcode, then a good single write.
    send(8'h12, c); send(8'h99, c);
    exp_err.push_back(c + 1);
    wait_idle("badop_idle");
    send_seq(8'h12, 8'h56, 8'h05, 8'h01);
    send_wr_data(8'h05, 8'h77);
    push_ack();
    wait_idle("after_badop_idle");

    // Timeout after opcode.
    send(8'h12, c); send(8'h56, c);
    exp_err.push_back(c + 50);
    repeat (60) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL timeout_idle busy=%0b need 0", busy);
    end
    send_seq(8'h12, 8'h56, 8'h00, 8'h00);
    push_ack();
    wait_idle("len0_write_idle");

    // Header+write opcode injected during a 2-byte read reply is dropped.
    exp_tx.push_back('{b: 8'h4A, rd: 1'b1, more: 1'b1});
    exp_tx.push_back('{b: 8'h4B, rd: 1'b1, more: 1'b0});
    send_seq(8'h12, 8'h34, 8'h10, 8'h02);
    send(8'h12, c); send(8'h56, c);
    wait_idle("overlap_idle");
    repeat (8) @(posedge sys_clk);

    // Reset while waiting for tx_done of the first read byte.
    exp_tx.push_back('{b: 8'h7A, rd: 1'b1, more: 1'b0});
    send_seq(8'h12, 8'h34, 8'h20, 8'h02);
    n = 0;
    @(negedge sys_clk);
    while (!tx_wr && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (!tx_wr) begin
      errors++;
      $display("FAIL rst_read_tx tx_wr=%0b need 1 within 50 cycles", tx_wr);
    end
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_zero("midread_reset_outputs");
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (12) @(posedge sys_clk);
    send_seq(8'h12, 8'h56, 8'h30, 8'h01);
    send_wr_data(8'h30, 8'h99);
    push_ack();
    wait_idle("after_reset_idle");

    repeat (10) @(posedge sys_clk);
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL wr_drain left=%0d need 0", exp_wr.size());
    end
    checks++;
    if (exp_tx.size() != 0) begin
      errors++;
      $display("FAIL tx_drain left=%0d need 0", exp_tx.size());
    end
    checks++;
    if (exp_err.size() != 0) begin
      errors++;
      $display("FAIL err_drain left=%0d need 0", exp_err.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded need finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between a uart_transceiver and an 8-bit register bus.
- Parses framed byte commands arriving on rx_data/rx_done.
- Issues register writes and reads.
- Returns read data by pacing tx_data/tx_wr against tx_done, one byte in flight at a time.
- Sits between the transceiver and the system register file, inside the top-level uart block.

Parameters:
HDR_BYTE, 8'h12, frame header byte
OP_WR, 8'h56, write opcode
OP_RD, 8'h34, read opcode
TIMEOUT_CYCLES, 65535, max sys_clk cycles between received bytes inside a frame; counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous reset, active-high
rx_data  in  8  received byte, valid when rx_done=1
rx_done  in  1  one-cycle pulse per received byte
tx_data  out  8  byte to transmit
tx_wr  out  1  one-cycle transmit strobe
tx_done  in  1  one-cycle pulse when the transceiver finishes a byte
reg_addr  out  8  register address
reg_wdata  out  8  register write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle pulse on bad opcode or timeout

Behaviour:
- Reset: sys_clk and sys_rst only; reset is synchronous and active-high. All outputs reset to 0; state=IDLE; address, length and timeout registers = 0. Reset mid-frame or mid-transmit aborts immediately, with no tx_wr or reg strobe issued afterwards. A transceiver byte already in flight is not tracked; a stale tx_done arriving in IDLE is ignored.
- Frame format:
  - Write: HDR OP_WR ADDR LEN D0..D(LEN-1).
  - Read: HDR OP_RD ADDR LEN; block replies with LEN bytes.
  - LEN=0 means no data phase; the frame completes after LEN.
- IDLE:
  - rx_done with rx_data==HDR_BYTE -> OPC.
  - Any other byte is silently discarded (no err).
- OPC:
  - OP_WR -> ADDR with mode=write.
  - OP_RD -> ADDR with mode=read.
  - Any other byte -> err pulse, IDLE.
- ADDR: latch addr. LEN: latch len; len==0 -> IDLE; else -> WDATA (write) or RREQ (read).
- WDATA: each rx_done drives, in the next cycle, reg_we=1, reg_addr=addr, reg_wdata=byte. Then addr increments (8-bit wrap, 8'hFF->8'h00) and len decrements; len reaches 0 -> IDLE (or ACK, see option).
- Read path:
  - RREQ: reg_re=1 for one cycle with reg_addr=addr -> RCAP.
  - RCAP: capture reg_rdata into tx_data, tx_wr=1 for one cycle -> TXWAIT.
  - TXWAIT: wait for tx_done. Then addr++ and len--; len!=0 -> RREQ, else IDLE.
  - Latency: reg_re to tx_wr = 1 cycle. tx_done to next reg_re = 1 cycle.
- Timeout:
  - Counter clears on every rx_done.
  - Increments each cycle in OPC/ADDR/LEN/WDATA.
  - Reaching TIMEOUT_CYCLES -> err pulse, IDLE.
  - Never counts in read/transmit states (tx pacing is unbounded).
- Simultaneous events: rx_done during RREQ/RCAP/TXWAIT/ACK is dropped; a new frame is only recognised after returning to IDLE. Timeout expiry and rx_done in the same cycle: rx_done wins.
- Invariants:
  - tx_wr is never asserted while a previous byte awaits tx_done.
  - reg_we and reg_re are never asserted together.

Optional Feature:
UART_CMD_ACK_EN:
- Defined: after the last write data byte, or after LEN for a write with LEN=0, the block enters ACK. It sends byte 8'hAC (tx_wr pulse), waits tx_done, then returns to IDLE.
- Undefined: the ACK state does not exist; the write frame ends directly in IDLE and nothing is transmitted for writes.

Decomposition:
- Shared package uart_pkg: state enum localparams, HDR_BYTE/OP_WR/OP_RD/ACK_BYTE constants.
- No sub-module. The timeout counter is inline; a separate module is not warranted.

Test Plan:
- Write, divisor=1: 12 56 01 03 AA BB CC -> three reg_we pulses at addr 01/02/03 with data AA/BB/CC, busy low afterwards, no tx_wr (with ACK_EN: one tx byte AC).
- Read: 12 34 FE 03, register model returning addr^8'h5A -> tx bytes A4 A5 5A (addr wraps FE, FF, 00). Each tx_wr exactly 1 cycle after its reg_re; next reg_re 1 cycle after tx_done.
- Bad opcode: 12 99 -> single err pulse, IDLE. Then 12 56 05 01 77 -> reg_we addr 05 data 77.
- Timeout, TIMEOUT_CYCLES=50: 12 56 then silence -> err exactly 50 cycles after the last rx_done, state IDLE. The following bytes 12 56 00 00 complete cleanly.
- Garbage/overlap: 00 FF before header ignored with no err. During a 2-byte read reply, inject rx 12 56 -> no reg_we, reply bytes unaffected.
- Reset mid-read, asserted while in TXWAIT -> all outputs 0 next cycle. A late tx_done produces no tx_wr; a new frame works.
